// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide, with signed fix-up and MADD/MSUB accumulation on completion.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] hilo_q, result_q;
  logic               neg_lo_q, neg_hi_q;
  logic               ready_q, busy_q, dbz_q;

  // Operand magnitudes and signs, evaluated on the accepting edge.
  logic               in_div, in_signed, s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;

  logic               q_div;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   hi_d, lo_d, rem_f, quo_f;
  logic [2*WIDTH-1:0] prod, prod_s, final_d;

  always_comb begin
    in_div    = !op_i[2] && op_i[1];
    in_signed = !op_i[0];
    s1        = in_signed && opdata1_i[WIDTH-1];
    s2        = in_signed && opdata2_i[WIDTH-1];
    mag1      = s1 ? -opdata1_i : opdata1_i;
    mag2      = s2 ? -opdata2_i : opdata2_i;
  end

  // NOTE: every always_comb output is assigned a default first so no path leaves
  // a value held, which would otherwise infer a latch.
  always_comb begin
    q_div     = !op_q[1] && op_q[0];
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    hi_d      = mul_sum[WIDTH:1];
    lo_d      = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (q_div) begin
      if (!div_diff[WIDTH]) begin
        hi_d = div_diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = div_shift[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end

    prod    = {hi_q, lo_q};
    prod_s  = neg_lo_q ? -prod : prod;
    rem_f   = neg_hi_q ? -hi_q : hi_q;
    quo_f   = neg_lo_q ? -lo_q : lo_q;
    final_d = prod_s;
    if (q_div) begin
      final_d = {rem_f, quo_f};
    end else if (op_q[1]) begin
      final_d = op_q[0] ? (hilo_q - prod_s) : (hilo_q + prod_s);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hilo_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && !annul_i) begin
            op_q     <= op_i[2:1];
            a_q      <= mag1;
            b_q      <= mag2;
            hi_q     <= '0;
            lo_q     <= in_div ? mag1 : mag2;
            hilo_q   <= hilo_i;
            neg_lo_q <= s1 ^ s2;
            neg_hi_q <= s1;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (in_div && opdata2_i == '0) begin
              state_q  <= DONE;
              result_q <= '0;
              dbz_q    <= 1'b1;
              ready_q  <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (annul_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CW'(WIDTH)) begin
            state_q  <= DONE;
            result_q <= final_d;
            dbz_q    <= 1'b0;
            ready_q  <= 1'b1;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result_o      = result_q;
  assign ready_o       = ready_q;
  assign busy_o        = busy_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (WIDTH=32): vector table plus annul/reset/start-hold sequences.
module tb_muldiv_iter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, start, annul;
  logic [2:0]     op;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] hilo, result;
  logic           ready, busy, dbz;

  int total = 0;
  int bad   = 0;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
    .opdata1_i(a), .opdata2_i(b), .hilo_i(hilo),
    .result_o(result), .ready_o(ready), .busy_o(busy), .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] hilo, exp;
    logic           dbz;
  } vec_t;

  localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011,
                         MADD = 3'b100, MADDU = 3'b101, MSUB = 3'b110, MSUBU = 3'b111;

  vec_t vecs[15];

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge while idle; returns at #1 after the accepting edge.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2*W-1:0] h);
    op = o; a = x; b = y; hilo = h; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges counted after the accepting edge until ready is seen (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  int n, pulses;
  logic [2*W-1:0] prior;

  initial begin
    vecs[0]  = '{DIVU,  32'h80000000, 32'h00000000, 64'h0, 64'h0, 1'b1};
    vecs[1]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 64'h0, 64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 64'h0, 64'h40000000_00000000, 1'b0};
    vecs[3]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFE_00000001, 1'b0};
    vecs[4]  = '{MADD,  32'hFFFFFFFF, 32'h00000003, 64'h00000001_00000000, 64'h00000000_FFFFFFFD, 1'b0};
    vecs[5]  = '{MSUB,  32'hFFFFFFFF, 32'h00000003, 64'h00000001_00000000, 64'h00000001_00000003, 1'b0};
    vecs[6]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 64'h0, 64'h00000000_80000000, 1'b0};
    vecs[7]  = '{DIVU,  32'd100,      32'd7,        64'h0, 64'h00000002_0000000E, 1'b0};
    vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 64'h0, 64'h00000001_FFFFFFFD, 1'b0};
    vecs[9]  = '{MULT,  32'd3,        32'hFFFFFFFB, 64'h0, 64'hFFFFFFFF_FFFFFFF1, 1'b0};
    vecs[10] = '{DIV,   32'd5,        32'd0,        64'h0, 64'h0, 1'b1};
    vecs[11] = '{MADDU, 32'd1,        32'd1,        64'hFFFFFFFF_FFFFFFFF, 64'h0, 1'b0};
    vecs[12] = '{MSUBU, 32'd2,        32'd3,        64'h0, 64'hFFFFFFFF_FFFFFFFA, 1'b0};
    vecs[13] = '{DIVU,  32'hFFFFFFFF, 32'd1,        64'h0, 64'h00000000_FFFFFFFF, 1'b0};
    vecs[14] = '{MULTU, 32'h12345678, 32'h10,       64'h0, 64'h00000001_23456780, 1'b0};

    rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0; a = '0; b = '0; hilo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 64'h0);
    check("reset_ready", 64'(ready), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_dbz", 64'(dbz), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo);
      check($sformatf("v%0d_busy", i), 64'(busy), 64'h1);
      wait_ready(n);
      check($sformatf("v%0d_latency", i), 64'(n), vecs[i].dbz ? 64'd0 : 64'd33);
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      check($sformatf("v%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
      @(posedge clk); #1;
      check($sformatf("v%0d_ready_off", i), 64'(ready), 64'h0);
      check($sformatf("v%0d_busy_off", i), 64'(busy), 64'h0);
    end

    // Annul in the middle of CALC; then a new start right after.
    prior = result;
    start_op(DIVU, 32'd100, 32'd7, 64'h0);
    repeat (9) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_busy", 64'(busy), 64'h0);
    check("annul_ready", 64'(ready), 64'h0);
    check("annul_result", result, prior);
    start_op(MULTU, 32'd6, 32'd7, 64'h0);
    check("restart_busy", 64'(busy), 64'h1);
    wait_ready(n);
    check("restart_latency", 64'(n), 64'd33);
    check("restart_result", result, 64'd42);
    @(posedge clk); #1;

    // Annul coinciding with the final CALC edge wins.
    prior = result;
    start_op(MULTU, 32'd9, 32'd9, 64'h0);
    repeat (32) begin @(posedge clk); #1; end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_last_ready", 64'(ready), 64'h0);
    check("annul_last_busy", 64'(busy), 64'h0);
    check("annul_last_result", result, prior);

    // Annul in IDLE blocks acceptance.
    op = MULTU; a = 32'd2; b = 32'd2; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    check("idle_annul_busy", 64'(busy), 64'h0);

    // start held high with operands changing during CALC.
    op = MULTU; a = 32'd2; b = 32'd3; hilo = '0; start = 1'b1;
    @(posedge clk); #1;
    pulses = 0; n = 0;
    while (!ready && n < 60) begin
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      n++;
      if (ready) pulses++;
    end
    start = 1'b0;
    check("hold_latency", 64'(n), 64'd33);
    check("hold_result", result, 64'd6);
    repeat (5) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_busy_off", 64'(busy), 64'h0);

    // Reset mid-operation.
    start_op(MULTU, 32'd5, 32'd5, 64'h0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_result", result, 64'h0);
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_ready", 64'(ready), 64'h0);
    check("rst_mid_dbz", 64'(dbz), 64'h0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("rst_mid_no_ready", 64'(pulses), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
